// File: rtl/decrement_pkg.sv
// Shared mode encoding for the decrementing counter family.
// The enum and the matching constants are used by other counter blocks too.
package decrement_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'd0,
        MODE_SAT    = 2'd1,
        MODE_RELOAD = 2'd2
    } mode_e;

    localparam logic [1:0] MODE_WRAP_ENC   = 2'd0;
    localparam logic [1:0] MODE_SAT_ENC    = 2'd1;
    localparam logic [1:0] MODE_RELOAD_ENC = 2'd2;
    localparam int         NUM_MODES       = 3;

    function automatic bit mode_supported(input mode_e mode);
        return (mode == MODE_WRAP) || (mode == MODE_SAT) || (mode == MODE_RELOAD);
    endfunction

endpackage

// File: rtl/decrement_next.sv
// Combinational WIDTH-bit subtract-by-one with borrow out.
// The borrow is 1 exactly when value is zero, in which case value_dec is all ones.
module decrement_next #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] value_dec,
    output logic             borrow
);

    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

    logic [WIDTH:0] diff;

    // One extra bit on the left catches the borrow out of the MSB.
    assign diff      = {1'b0, value} - ONE;
    assign value_dec = diff[WIDTH-1:0];
    assign borrow    = diff[WIDTH];

endmodule

// File: rtl/decrement_counter.sv
// Loadable down-counter with a selectable underflow policy (wrap, saturate, reload).
// Q and Cout are registered; Zero is decoded from Q only.
module decrement_counter
    import decrement_pkg::*;
#(
    parameter int    WIDTH = 8,
    parameter mode_e MODE  = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    input  logic             en,
    output logic [WIDTH-1:0] Q,
    output logic             Cout,
    output logic             Zero
);

    if (WIDTH < 1) begin : g_bad_width
        $error("decrement_counter: WIDTH must be >= 1");
    end

    if (!mode_supported(MODE)) begin : g_bad_mode
        $error("decrement_counter: unsupported MODE value");
    end

    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] dec_value;
    logic             borrow;

    decrement_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .value    (Q),
        .value_dec(dec_value),
        .borrow   (borrow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            Q        <= '0;
            reload_q <= '0;
            Cout     <= 1'b0;
        end else if (load) begin
            Q        <= D;
            reload_q <= D;
            Cout     <= 1'b0;
        end else if (en) begin
            if (!borrow) begin
                Q    <= dec_value;
                Cout <= 1'b0;
            end else begin
                // Underflow: the policy decides both the new count and the pulse.
                unique case (MODE)
                    MODE_WRAP: begin
                        Q    <= dec_value;
                        Cout <= 1'b1;
                    end
                    MODE_SAT: begin
                        Q    <= '0;
                        Cout <= 1'b0;
                    end
                    MODE_RELOAD: begin
                        Q    <= reload_q;
                        Cout <= 1'b1;
                    end
                    default: begin
                        Q    <= Q;
                        Cout <= 1'b0;
                    end
                endcase
            end
        end else begin
            Cout <= 1'b0;
        end
    end

    assign Zero = (Q == '0);

endmodule

// File: tb/tb_decrement_counter.sv
// Directed bench for decrement_counter across five WIDTH/MODE configurations,
// checked every cycle against a spec-level model plus literal expected sequences.
module tb_decrement_counter;
    import decrement_pkg::*;

    localparam int N = 5;

    logic       clk;
    logic       rst_v  [N];
    logic       ld_v   [N];
    logic       en_v   [N];
    logic [7:0] d_v    [N];

    logic [7:0] q0, q1, q3;
    logic [3:0] q2;
    logic [0:0] q4;
    logic       cout_v [N];
    logic       zero_v [N];
    logic [7:0] qa     [N];

    int    total;
    int    bad;
    bit    checking;

    int    wid   [N] = '{8, 8, 4, 8, 1};
    mode_e mds   [N] = '{MODE_WRAP, MODE_SAT, MODE_RELOAD, MODE_RELOAD, MODE_WRAP};
    int    m_q   [N];
    int    m_rel [N];
    int    m_c   [N];
    bit    m_ok  [N];

    decrement_counter #(.WIDTH(8), .MODE(MODE_WRAP)) u_wrap8 (
        .clk(clk), .reset(rst_v[0]), .load(ld_v[0]), .D(d_v[0]), .en(en_v[0]),
        .Q(q0), .Cout(cout_v[0]), .Zero(zero_v[0]));
    decrement_counter #(.WIDTH(8), .MODE(MODE_SAT)) u_sat8 (
        .clk(clk), .reset(rst_v[1]), .load(ld_v[1]), .D(d_v[1]), .en(en_v[1]),
        .Q(q1), .Cout(cout_v[1]), .Zero(zero_v[1]));
    decrement_counter #(.WIDTH(4), .MODE(MODE_RELOAD)) u_rel4 (
        .clk(clk), .reset(rst_v[2]), .load(ld_v[2]), .D(d_v[2][3:0]), .en(en_v[2]),
        .Q(q2), .Cout(cout_v[2]), .Zero(zero_v[2]));
    decrement_counter #(.WIDTH(8), .MODE(MODE_RELOAD)) u_rel8 (
        .clk(clk), .reset(rst_v[3]), .load(ld_v[3]), .D(d_v[3]), .en(en_v[3]),
        .Q(q3), .Cout(cout_v[3]), .Zero(zero_v[3]));
    decrement_counter #(.WIDTH(1), .MODE(MODE_WRAP)) u_wrap1 (
        .clk(clk), .reset(rst_v[4]), .load(ld_v[4]), .D(d_v[4][0:0]), .en(en_v[4]),
        .Q(q4), .Cout(cout_v[4]), .Zero(zero_v[4]));

    always_comb begin
        qa[0] = q0;
        qa[1] = q1;
        qa[2] = {4'b0, q2};
        qa[3] = q3;
        qa[4] = {7'b0, q4};
    end

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model ----------------
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            int top;
            top = (1 << wid[i]) - 1;
            if (rst_v[i]) begin
                m_q[i] = 0; m_rel[i] = 0; m_c[i] = 0; m_ok[i] = 1'b1;
            end else if (ld_v[i]) begin
                m_q[i] = int'(d_v[i]) & top; m_rel[i] = m_q[i]; m_c[i] = 0;
            end else if (en_v[i]) begin
                if (m_q[i] != 0) begin
                    m_q[i] = m_q[i] - 1; m_c[i] = 0;
                end else if (mds[i] == MODE_WRAP) begin
                    m_q[i] = top; m_c[i] = 1;
                end else if (mds[i] == MODE_SAT) begin
                    m_c[i] = 0;
                end else begin
                    m_q[i] = m_rel[i]; m_c[i] = 1;
                end
            end else begin
                m_c[i] = 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < N; i++) begin
                if (m_ok[i]) begin
                    chk($sformatf("model_q[%0d]", i), int'(qa[i]), m_q[i]);
                    chk($sformatf("model_cout[%0d]", i), int'(cout_v[i]), m_c[i]);
                    chk($sformatf("model_zero[%0d]", i), int'(zero_v[i]), (m_q[i] == 0) ? 1 : 0);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            rst_v[i] = 1'b0; ld_v[i] = 1'b0; en_v[i] = 1'b0; d_v[i] = 8'd0;
        end
    endtask

    // Apply one cycle of stimulus to instance i, then return at the next negedge.
    task automatic cyc(input int i, input bit r, input bit l, input bit e, input int dv);
        rst_v[i] = r; ld_v[i] = l; en_v[i] = e; d_v[i] = 8'(dv);
        @(negedge clk);
        idle_all();
    endtask

    task automatic lit(input string tag, input int i, input int eq, input int ec);
        chk({tag, "_q"}, int'(qa[i]), eq);
        chk({tag, "_cout"}, int'(cout_v[i]), ec);
    endtask

    initial begin
        int wq[5]  = '{2, 1, 0, 255, 254};
        int wc[5]  = '{0, 0, 0, 1, 0};
        int rq[7]  = '{1, 0, 2, 1, 0, 2, 1};
        int rc[7]  = '{0, 0, 1, 0, 0, 1, 0};
        int bq[4]  = '{1, 0, 1, 0};
        int bc[4]  = '{1, 0, 1, 0};

        total = 0; bad = 0; checking = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_q[i] = 0; m_rel[i] = 0; m_c[i] = 0; m_ok[i] = 1'b0;
        end
        idle_all();
        for (int i = 0; i < N; i++) begin
            rst_v[i] = 1'b1; ld_v[i] = 1'b1; en_v[i] = 1'b1; d_v[i] = 8'hff;
        end
        @(negedge clk);
        idle_all();
        checking = 1'b1;
        for (int i = 0; i < N; i++) begin
            lit($sformatf("reset[%0d]", i), i, 0, 0);
            chk($sformatf("reset_zero[%0d]", i), int'(zero_v[i]), 1);
        end

        // wrap, width 8
        cyc(0, 0, 1, 0, 3);
        lit("wrap_load", 0, 3, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 1, 0);
            lit($sformatf("wrap_%0d", k), 0, wq[k], wc[k]);
        end
        cyc(0, 0, 0, 0, 0);
        lit("wrap_hold", 0, 254, 0);

        // saturate, width 8
        cyc(1, 0, 1, 0, 1);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 0, 1, 0);
            lit($sformatf("sat_%0d", k), 1, 0, 0);
            chk($sformatf("sat_zero_%0d", k), int'(zero_v[1]), 1);
        end

        // reload, width 4
        cyc(2, 0, 1, 0, 2);
        for (int k = 0; k < 7; k++) begin
            cyc(2, 0, 0, 1, 0);
            lit($sformatf("rel4_%0d", k), 2, rq[k], rc[k]);
        end

        // simultaneous events, width 8 wrap
        cyc(0, 0, 1, 0, 5);
        lit("sim_pre", 0, 5, 0);
        cyc(0, 0, 1, 1, 9);
        lit("sim_load_en", 0, 9, 0);
        cyc(0, 1, 1, 1, 77);
        lit("sim_reset_load", 0, 0, 0);

        // width 1 toggling decrementer
        cyc(4, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(4, 0, 0, 1, 0);
            lit($sformatf("w1_%0d", k), 4, bq[k], bc[k]);
        end

        // reset mid-count, width 8 reload
        cyc(3, 0, 1, 0, 10);
        for (int k = 0; k < 3; k++) cyc(3, 0, 0, 1, 0);
        lit("rel8_mid", 3, 7, 0);
        cyc(3, 1, 0, 1, 0);
        lit("rel8_reset", 3, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(3, 0, 0, 1, 0);
            lit($sformatf("rel8_zero_reload_%0d", k), 3, 0, 1);
        end
        cyc(3, 0, 0, 0, 0);
        lit("rel8_idle", 3, 0, 0);

        @(negedge clk);
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decrement_counter.md
DECREMENT_COUNTER -- requirements
Module: decrement_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits; the block SHALL accept any WIDTH >= 1.
REQ-002 Parameter MODE, default MODE_WRAP, selects the underflow policy; the values are MODE_WRAP, MODE_SAT and MODE_RELOAD.
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, reset; it SHALL be synchronous and active-high.
REQ-005 Port load, input, 1, loads D into Q and into the reload register.
REQ-006 Port D, input, WIDTH, the load value.
REQ-007 Port en, input, 1, requests one decrement per cycle.
REQ-008 Port Q, output, WIDTH, the registered count.
REQ-009 Port Cout, output, 1, registered borrow pulse.
REQ-010 Port Zero, output, 1, combinational flag equal to (Q == 0).

Function
REQ-011 Per-edge priority SHALL be: reset, then load, then en, then hold.
REQ-012 load=1: Q <= D, reload register <= D, Cout <= 0; en SHALL be ignored that cycle, with no decrement.
REQ-013 en=1, load=0, Q != 0: Q <= Q - 1 modulo 2^WIDTH, Cout <= 0.
REQ-014 en=1, load=0, Q == 0, MODE_WRAP: Q <= all-ones, Cout <= 1.
REQ-015 en=1, load=0, Q == 0, MODE_SAT: Q stays 0, Cout <= 0.
REQ-016 en=1, load=0, Q == 0, MODE_RELOAD: Q <= reload register, Cout <= 1.
REQ-017 MODE_RELOAD with reload register == 0: Q SHALL stay 0 and Cout SHALL pulse on every enabled cycle.
REQ-018 en=0, load=0: Q and the reload register SHALL hold, and Cout <= 0.
REQ-019 Cout SHALL be high for exactly one cycle per underflow event, coincident with the new Q value.
REQ-020 Decrement latency SHALL be one cycle, from the en sample edge to the updated Q.
REQ-021 Continuous en from load value N SHALL produce Cout after exactly N+1 enabled cycles (MODE_WRAP and MODE_RELOAD).
REQ-022 WIDTH=1 with MODE_WRAP SHALL behave as a 1-bit toggling decrementer: 1 -> 0 gives Cout=0; 0 -> 1 gives Cout=1.
REQ-023 An unsupported MODE value SHALL cause an elaboration-time error.
REQ-024 The block SHALL contain no combinational path from inputs to Q or Cout; Zero depends only on Q.

Reset
REQ-025 When reset=1 at a clock edge: Q <= 0, reload register <= 0, Cout <= 0, so Zero reads 1 after that edge.
REQ-026 Reset SHALL override a simultaneous load or en.
REQ-027 Reset asserted mid-count SHALL discard the count; on the first cycle after release the block SHALL respond to load/en normally.
REQ-028 Before the first reset edge, outputs are undefined; no behaviour is required.

Structure
REQ-029 Package decrement_pkg SHALL hold the mode encoding (MODE_WRAP=0, MODE_SAT=1, MODE_RELOAD=2) as a typedef enum plus constants, shared with other counter blocks.
REQ-030 The WIDTH-bit subtract-with-borrow SHALL be a single combinational sub-module, decrement_next, with inputs value and outputs value-1 and borrow (borrow=1 when value==0).
REQ-031 The state registers (Q, reload register, Cout) and the mode policy SHALL reside in decrement_counter only.

Verification
REQ-032 WIDTH=8, MODE_WRAP: reset; load D=3; en held for 5 cycles -> Q = 2,1,0,255,254; Cout=1 only on the cycle Q=255.
REQ-033 WIDTH=8, MODE_SAT: load D=1; en held for 4 cycles -> Q = 0,0,0,0; Cout stays 0; Zero=1 from the first decrement onward.
REQ-034 WIDTH=4, MODE_RELOAD: load D=2; en held for 7 cycles -> Q = 1,0,2,1,0,2,1; Cout=1 on both cycles where Q returns to 2.
REQ-035 Simultaneous events, WIDTH=8: Q=5 with load=1, D=9, en=1 -> Q=9, Cout=0; then reset=1 with load=1 -> Q=0, Cout=0.
REQ-036 WIDTH=1, MODE_WRAP: reset, then en held for 4 cycles -> Q = 1,0,1,0; Cout = 1,0,1,0.
REQ-037 Reset mid-count: WIDTH=8, MODE_RELOAD, load D=10, 3 decrements, then reset -> Q=0; en after release -> Q=0 and Cout=1 each cycle (reload register cleared).
